program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
- Front-end writer for the 16-bit MCU's instruction memory, and the counterpart of the core's fetch path.
- Accepts a byte stream with a valid/ready handshake, packs byte pairs into 16-bit words, and writes them sequentially into instruction memory.
- Holds the core stalled until the program is complete, then releases it.
- Monitors fetched instructions and stops the core on the halt opcode (upper nibble 4'b1111).

Parameters:
ADDR_W, 8, instruction memory address width (depth 2^ADDR_W words)
HALT_OP, 4'hF, opcode in instr[15:12] that halts the core

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  byte stream valid
in_byte  input  8  byte stream data
in_last  input  1  marks final byte of program; qualified by in_valid
in_ready  output  1  loader can accept a byte this cycle
mem_we  output  1  instruction memory write strobe
mem_addr  output  ADDR_W  instruction memory write address
mem_wdata  output  16  instruction memory write data
instr  input  16  instruction currently fetched by the core
instr_valid  input  1  instr is a valid fetch this cycle
core_run  output  1  core enable; 0 stalls the core
halted  output  1  sticky, halt opcode seen
load_err  output  1  sticky, program exceeded memory depth
word_count  output  ADDR_W+1  number of words written since reset

Behaviour:
- Reset (async, rst_n=0):
  - State LOAD_HI, write pointer 0, word_count 0.
  - in_ready=0 during reset; in_ready=1 from the first clock edge after rst_n deasserts.
  - mem_we=0, mem_addr=0, mem_wdata=0, core_run=0, halted=0, load_err=0.
- Byte transfer: a byte transfers on a rising edge with in_valid=1 and in_ready=1. No transfer occurs otherwise. in_byte and in_last are sampled only on transfer.
- All outputs are registered.
- States: LOAD_HI, LOAD_LO, WRITE, RUN, HALT, ERR.
- LOAD_HI:
  - in_ready=1.
  - On transfer: hi_reg<=in_byte.
  - If in_last=1: lo_reg<=8'h00, last_flag<=1, go to WRITE (odd-length program is zero-padded).
  - Otherwise go to LOAD_LO.
- LOAD_LO:
  - in_ready=1.
  - On transfer: lo_reg<=in_byte, last_flag<=in_last, go to WRITE.
- WRITE (exactly one cycle):
  - in_ready=0, mem_we=1, mem_addr=ptr, mem_wdata={hi_reg,lo_reg}. High byte is first on the stream (big-endian).
  - On exit: ptr increments and word_count increments.
  - If last_flag=1: go to RUN.
  - Else if ptr was 2^ADDR_W-1: go to ERR.
  - Else: go to LOAD_HI.
- Load latency: the memory write strobe asserts the cycle after the low-byte transfer. Sustained throughput is 2 bytes per 3 cycles.
- Pointer wrap: ptr never wraps. A full memory with more data pending is an error, not a wrap.
- RUN:
  - core_run=1, in_ready=0.
  - If instr_valid=1 and instr[15:12]==HALT_OP, then on that edge: core_run<=0, halted<=1, go to HALT.
  - Non-halt fetches have no effect.
- HALT:
  - core_run=0, halted=1, in_ready=0.
  - Terminal; only rst_n exits.
- ERR:
  - load_err=1, core_run=0, in_ready=0.
  - Terminal; only rst_n exits. No memory writes occur in ERR.
- instr_valid outside RUN is ignored, including a halt opcode.
- Bytes offered while in_ready=0 are not consumed; the sender must hold them.
- Reset mid-load or mid-run aborts immediately. Memory contents are not cleared. Reload always restarts at address 0.
- mem_addr and mem_wdata hold their last values when mem_we=0.
- word_count width ADDR_W+1 lets it reach 2^ADDR_W without overflow.

Test Plan:
1. Reset, then stream 12 34 56 78(last) with in_valid held high -> writes 16'h1234@0 and 16'h5678@1, each one cycle after the low byte. word_count=2. core_run=1 the cycle after the second write.
2. Stream AB CD EE(last) -> writes 16'hABCD@0 and 16'hEE00@1. word_count=2. Enters RUN.
3. In RUN, drive instr=16'h3001 valid, then 16'hF000 with instr_valid=0, then 16'hF000 with instr_valid=1 -> core_run stays 1 through the first two. core_run falls to 0 and halted=1 after the third edge. Both persist until reset.
4. ADDR_W=2: stream 10 bytes, last on byte 10 -> four writes to addresses 0..3. After the fourth write: load_err=1, in_ready=0, bytes 9-10 not accepted, core_run=0.
5. Toggle in_valid randomly with gaps and check in_ready deassertion during WRITE -> memory image identical to a gap-free transfer, no byte lost or duplicated.
6. Assert rst_n=0 asynchronously mid-WRITE and mid-RUN -> mem_we, core_run, halted and load_err drop to 0 without waiting for a clock edge. word_count=0. The next load writes starting at address 0.

Source files
------------

// File: rtl/program_loader.sv
// Byte-stream loader for the MCU instruction memory: packs big-endian byte pairs
// into 16-bit words, writes them sequentially, then runs the core until a halt opcode.
module program_loader #(
    parameter int unsigned ADDR_W  = 8,
    parameter logic [3:0]  HALT_OP = 4'hF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [7:0]        in_byte,
    input  logic              in_last,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       instr,
    input  logic              instr_valid,
    output logic              core_run,
    output logic              halted,
    output logic              load_err,
    output logic [ADDR_W:0]   word_count
);

    typedef enum logic [2:0] {
        LOAD_HI,
        LOAD_LO,
        WRITE,
        RUN,
        HALT,
        ERR
    } state_t;

    localparam logic [ADDR_W-1:0] PTR_ONE = 1;
    localparam logic [ADDR_W-1:0] PTR_MAX = '1;
    localparam logic [ADDR_W:0]   CNT_ONE = 1;

    state_t              state_q;
    logic [7:0]          hi_q;
    logic                last_q;
    logic [ADDR_W-1:0]   ptr_q;
    logic [ADDR_W:0]     word_count_q;
    logic                in_ready_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [15:0]         mem_wdata_q;
    logic                core_run_q;
    logic                halted_q;
    logic                load_err_q;

    logic xfer;
    logic halt_fetch;
    logic unused_instr_bits;

    assign xfer              = in_valid & in_ready_q;
    assign halt_fetch        = instr_valid && (instr[15:12] == HALT_OP);
    assign unused_instr_bits = ^instr[11:0];

    // Outputs are registered alongside the state so each one reflects the
    // state being entered on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= LOAD_HI;
            hi_q         <= 8'h00;
            last_q       <= 1'b0;
            ptr_q        <= '0;
            word_count_q <= '0;
            in_ready_q   <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= 16'h0000;
            core_run_q   <= 1'b0;
            halted_q     <= 1'b0;
            load_err_q   <= 1'b0;
        end else begin
            case (state_q)
                LOAD_HI: begin
                    in_ready_q <= 1'b1;
                    if (xfer) begin
                        hi_q <= in_byte;
                        if (in_last) begin
                            // Odd-length program: pad the final low byte with zero.
                            last_q      <= 1'b1;
                            in_ready_q  <= 1'b0;
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= ptr_q;
                            mem_wdata_q <= {in_byte, 8'h00};
                            state_q     <= WRITE;
                        end else begin
                            state_q <= LOAD_LO;
                        end
                    end
                end
                LOAD_LO: begin
                    if (xfer) begin
                        last_q      <= in_last;
                        in_ready_q  <= 1'b0;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= ptr_q;
                        mem_wdata_q <= {hi_q, in_byte};
                        state_q     <= WRITE;
                    end
                end
                WRITE: begin
                    mem_we_q     <= 1'b0;
                    ptr_q        <= ptr_q + PTR_ONE;
                    word_count_q <= word_count_q + CNT_ONE;
                    if (last_q) begin
                        core_run_q <= 1'b1;
                        state_q    <= RUN;
                    end else if (ptr_q == PTR_MAX) begin
                        // Memory full with more data pending: refuse rather than wrap.
                        load_err_q <= 1'b1;
                        state_q    <= ERR;
                    end else begin
                        in_ready_q <= 1'b1;
                        state_q    <= LOAD_HI;
                    end
                end
                RUN: begin
                    if (halt_fetch) begin
                        core_run_q <= 1'b0;
                        halted_q   <= 1'b1;
                        state_q    <= HALT;
                    end
                end
                HALT: begin
                    state_q <= HALT;
                end
                ERR: begin
                    state_q <= ERR;
                end
                default: begin
                    in_ready_q <= 1'b0;
                    mem_we_q   <= 1'b0;
                    core_run_q <= 1'b0;
                    load_err_q <= 1'b1;
                    state_q    <= ERR;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign core_run   = core_run_q;
    assign halted     = halted_q;
    assign load_err   = load_err_q;
    assign word_count = word_count_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: a full-depth instance and a 4-word instance
// that exercises the overflow path.
`timescale 1ns/1ps
module tb_program_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        m_valid, m_last, m_ready, m_we, m_run, m_halted, m_err, m_ivalid;
    logic [7:0]  m_byte, m_addr;
    logic [15:0] m_wdata, m_instr;
    logic [8:0]  m_wc;

    logic        s_valid, s_last, s_ready, s_we, s_run, s_halted, s_err, s_ivalid;
    logic [7:0]  s_byte;
    logic [1:0]  s_addr;
    logic [15:0] s_wdata, s_instr;
    logic [2:0]  s_wc;

    program_loader #(.ADDR_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(m_valid), .in_byte(m_byte), .in_last(m_last), .in_ready(m_ready),
        .mem_we(m_we), .mem_addr(m_addr), .mem_wdata(m_wdata),
        .instr(m_instr), .instr_valid(m_ivalid),
        .core_run(m_run), .halted(m_halted), .load_err(m_err), .word_count(m_wc)
    );

    program_loader #(.ADDR_W(2)) u_small (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_valid), .in_byte(s_byte), .in_last(s_last), .in_ready(s_ready),
        .mem_we(s_we), .mem_addr(s_addr), .mem_wdata(s_wdata),
        .instr(s_instr), .instr_valid(s_ivalid),
        .core_run(s_run), .halted(s_halted), .load_err(s_err), .word_count(s_wc)
    );

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    int ready_viol = 0;

    typedef struct {
        int          addr;
        logic [15:0] data;
        int          cyc;
    } wr_t;
    wr_t log_m[$];
    wr_t log_s[$];

    always @(posedge clk) cyc++;

    // Write strobes are logged mid-cycle, tagged with the cycle they belong to.
    always @(negedge clk) begin
        if (m_we === 1'b1) begin
            log_m.push_back('{int'(m_addr), m_wdata, cyc});
            if (m_ready !== 1'b0) ready_viol++;
        end
        if (s_we === 1'b1) log_s.push_back('{int'(s_addr), s_wdata, cyc});
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        m_valid = 0; m_last = 0; m_byte = 0; m_ivalid = 0; m_instr = 0;
        s_valid = 0; s_last = 0; s_byte = 0; s_ivalid = 0; s_instr = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        @(posedge clk); #1 rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        log_m.delete();
        log_s.delete();
        @(posedge clk); #1;
    endtask

    task automatic send_byte(input bit sel, input logic [7:0] b, input bit last, output int xcyc);
        bit acc;
        int n;
        acc = 0;
        n   = 0;
        if (sel) begin s_valid = 1; s_byte = b; s_last = last; end
        else     begin m_valid = 1; m_byte = b; m_last = last; end
        while (!acc && n < 20) begin
            acc = sel ? s_ready : m_ready;
            @(posedge clk); #1;
            n++;
        end
        xcyc = cyc;
        total++;
        if (!acc) $display("FAIL handshake: byte %02h got not-accepted expected accepted within %0d cycles", b, n);
        else passed++;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({m_ready, m_we, m_addr, m_wdata, m_run, m_halted, m_err, m_wc} !== '0)
            $display("FAIL reset_outputs: got rdy=%b we=%b addr=%h wd=%h run=%b h=%b err=%b wc=%0d expected all 0",
                     m_ready, m_we, m_addr, m_wdata, m_run, m_halted, m_err, m_wc);
        else passed++;
        rst_n = 1;
        #1;
        total++;
        if (m_ready !== 1'b0) $display("FAIL reset_ready_before_edge: got %b expected 0", m_ready);
        else passed++;
        @(posedge clk); #1;
        total++;
        if (m_ready !== 1'b1 || s_ready !== 1'b1)
            $display("FAIL reset_ready_after_edge: got %b/%b expected 1/1", m_ready, s_ready);
        else passed++;
    endtask

    task automatic test_basic_load();
        int c1, c2, xc;
        do_reset();
        send_byte(0, 8'h12, 0, xc);
        send_byte(0, 8'h34, 0, c1);
        send_byte(0, 8'h56, 0, xc);
        send_byte(0, 8'h78, 1, c2);
        m_valid = 0; m_last = 0;
        total++;
        if (m_we !== 1'b1 || m_run !== 1'b0)
            $display("FAIL basic_write_phase: got we=%b run=%b expected we=1 run=0", m_we, m_run);
        else passed++;
        @(posedge clk); #1;
        total++;
        if (m_run !== 1'b1 || m_we !== 1'b0 || m_ready !== 1'b0)
            $display("FAIL basic_run: got run=%b we=%b rdy=%b expected 1 0 0", m_run, m_we, m_ready);
        else passed++;
        total++;
        if (m_wc !== 9'd2) $display("FAIL basic_wc: got %0d expected 2", m_wc);
        else passed++;
        total++;
        if (log_m.size() != 2) $display("FAIL basic_nwrites: got %0d expected 2", log_m.size());
        else passed++;
        if (log_m.size() == 2) begin
            total++;
            if (log_m[0].addr != 0 || log_m[0].data !== 16'h1234 || log_m[0].cyc != c1)
                $display("FAIL basic_w0: got %h@%0d cyc %0d expected 1234@0 cyc %0d",
                         log_m[0].data, log_m[0].addr, log_m[0].cyc, c1);
            else passed++;
            total++;
            if (log_m[1].addr != 1 || log_m[1].data !== 16'h5678 || log_m[1].cyc != c2)
                $display("FAIL basic_w1: got %h@%0d cyc %0d expected 5678@1 cyc %0d",
                         log_m[1].data, log_m[1].addr, log_m[1].cyc, c2);
            else passed++;
        end
    endtask

    task automatic test_odd_length();
        int xc;
        do_reset();
        send_byte(0, 8'hAB, 0, xc);
        send_byte(0, 8'hCD, 0, xc);
        send_byte(0, 8'hEE, 1, xc);
        m_valid = 0; m_last = 0;
        @(posedge clk); #1;
        total++;
        if (m_run !== 1'b1 || m_wc !== 9'd2)
            $display("FAIL odd_run: got run=%b wc=%0d expected run=1 wc=2", m_run, m_wc);
        else passed++;
        total++;
        if (log_m.size() != 2 || log_m[0].addr != 0 || log_m[0].data !== 16'hABCD
            || log_m[1].addr != 1 || log_m[1].data !== 16'hEE00)
            $display("FAIL odd_writes: got %0d writes, first %h expected ABCD@0 EE00@1",
                     log_m.size(), (log_m.size() > 0) ? log_m[0].data : 16'hxxxx);
        else passed++;
    endtask

    task automatic test_halt();
        m_instr = 16'h3001; m_ivalid = 1;
        @(posedge clk); #1;
        total++;
        if (m_run !== 1'b1 || m_halted !== 1'b0)
            $display("FAIL halt_nonhalt: got run=%b halted=%b expected 1 0", m_run, m_halted);
        else passed++;
        m_instr = 16'hF000; m_ivalid = 0;
        @(posedge clk); #1;
        total++;
        if (m_run !== 1'b1) $display("FAIL halt_invalid_fetch: got run=%b expected 1", m_run);
        else passed++;
        m_ivalid = 1;
        @(posedge clk); #1;
        total++;
        if (m_run !== 1'b0 || m_halted !== 1'b1)
            $display("FAIL halt_trigger: got run=%b halted=%b expected 0 1", m_run, m_halted);
        else passed++;
        m_instr = 16'h3001;
        repeat (3) @(posedge clk);
        #1;
        m_ivalid = 0;
        total++;
        if (m_run !== 1'b0 || m_halted !== 1'b1 || m_ready !== 1'b0)
            $display("FAIL halt_sticky: got run=%b halted=%b rdy=%b expected 0 1 0", m_run, m_halted, m_ready);
        else passed++;
    endtask

    task automatic test_overflow();
        int xc;
        do_reset();
        for (int i = 1; i <= 8; i++) send_byte(1, 8'(i), 0, xc);
        @(posedge clk); #1;
        total++;
        if (s_err !== 1'b1 || s_ready !== 1'b0 || s_run !== 1'b0 || s_wc !== 3'd4)
            $display("FAIL ovf_state: got err=%b rdy=%b run=%b wc=%0d expected 1 0 0 4",
                     s_err, s_ready, s_run, s_wc);
        else passed++;
        s_valid = 1; s_byte = 8'h09; s_last = 0;
        repeat (4) @(posedge clk);
        #1;
        s_byte = 8'h0A; s_last = 1;
        repeat (4) @(posedge clk);
        #1;
        s_valid = 0; s_last = 0;
        total++;
        if (s_err !== 1'b1 || s_ready !== 1'b0 || s_wc !== 3'd4)
            $display("FAIL ovf_refuse: got err=%b rdy=%b wc=%0d expected 1 0 4", s_err, s_ready, s_wc);
        else passed++;
        total++;
        if (log_s.size() != 4) $display("FAIL ovf_nwrites: got %0d expected 4", log_s.size());
        else passed++;
        if (log_s.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                logic [15:0] exp_d;
                exp_d = {8'(2 * i + 1), 8'(2 * i + 2)};
                total++;
                if (log_s[i].addr != i || log_s[i].data !== exp_d)
                    $display("FAIL ovf_w%0d: got %h@%0d expected %h@%0d",
                             i, log_s[i].data, log_s[i].addr, exp_d, i);
                else passed++;
            end
        end
    endtask

    task automatic test_gaps();
        logic [7:0] bytes [6];
        int xc, g;
        bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33;
        bytes[3] = 8'h44; bytes[4] = 8'h55; bytes[5] = 8'h66;
        do_reset();
        ready_viol = 0;
        // A halt opcode while loading must be ignored.
        m_instr = 16'hF000; m_ivalid = 1;
        for (int i = 0; i < 6; i++) begin
            if (i == 5) m_ivalid = 0;
            send_byte(0, bytes[i], i == 5, xc);
            if (i < 5) begin
                g = $urandom_range(0, 3);
                if (g > 0) begin
                    m_valid = 0;
                    repeat (g) @(posedge clk);
                    #1;
                end
            end
        end
        m_valid = 0; m_last = 0;
        total++;
        if (m_halted !== 1'b0) $display("FAIL gaps_halt_ignored: got halted=%b expected 0", m_halted);
        else passed++;
        @(posedge clk); #1;
        total++;
        if (m_run !== 1'b1 || m_wc !== 9'd3)
            $display("FAIL gaps_run: got run=%b wc=%0d expected 1 3", m_run, m_wc);
        else passed++;
        total++;
        if (ready_viol != 0) $display("FAIL gaps_ready_in_write: got %0d violations expected 0", ready_viol);
        else passed++;
        total++;
        if (log_m.size() != 3 || log_m[0].data !== 16'h1122 || log_m[1].data !== 16'h3344
            || log_m[2].data !== 16'h5566 || log_m[2].addr != 2)
            $display("FAIL gaps_image: got %0d writes expected 1122 3344 5566 @0..2", log_m.size());
        else passed++;
    endtask

    task automatic test_async_reset();
        int xc;
        do_reset();
        send_byte(0, 8'hA1, 0, xc);
        send_byte(0, 8'hA2, 0, xc);
        send_byte(0, 8'hA3, 0, xc);
        send_byte(0, 8'hA4, 0, xc);
        m_valid = 0;
        total++;
        if (m_we !== 1'b1 || m_wc !== 9'd1)
            $display("FAIL arst_pre_write: got we=%b wc=%0d expected 1 1", m_we, m_wc);
        else passed++;
        #2 rst_n = 0;
        #1;
        total++;
        if (m_we !== 1'b0 || m_wc !== 9'd0 || m_ready !== 1'b0)
            $display("FAIL arst_mid_write: got we=%b wc=%0d rdy=%b expected 0 0 0", m_we, m_wc, m_ready);
        else passed++;
        @(posedge clk); #1 rst_n = 1;
        log_m.delete();
        @(posedge clk); #1;
        send_byte(0, 8'h5A, 0, xc);
        send_byte(0, 8'h5B, 1, xc);
        m_valid = 0; m_last = 0;
        @(posedge clk); #1;
        total++;
        if (m_run !== 1'b1 || log_m.size() != 1 || log_m[0].addr != 0 || log_m[0].data !== 16'h5A5B)
            $display("FAIL arst_reload: got run=%b %0d writes expected run=1 5A5B@0", m_run, log_m.size());
        else passed++;
        #2 rst_n = 0;
        #1;
        total++;
        if (m_run !== 1'b0) $display("FAIL arst_mid_run: got run=%b expected 0", m_run);
        else passed++;
        @(posedge clk); #1 rst_n = 1;
        @(posedge clk); #1;
        send_byte(0, 8'h01, 0, xc);
        send_byte(0, 8'h02, 1, xc);
        m_valid = 0; m_last = 0;
        @(posedge clk); #1;
        m_instr = 16'hF123; m_ivalid = 1;
        @(posedge clk); #1;
        m_ivalid = 0;
        for (int i = 1; i <= 8; i++) send_byte(1, 8'(i), 0, xc);
        s_valid = 0;
        @(posedge clk); #1;
        total++;
        if (m_halted !== 1'b1 || s_err !== 1'b1)
            $display("FAIL arst_pre_sticky: got halted=%b err=%b expected 1 1", m_halted, s_err);
        else passed++;
        #2 rst_n = 0;
        #1;
        total++;
        if (m_halted !== 1'b0 || s_err !== 1'b0 || s_wc !== 3'd0)
            $display("FAIL arst_sticky_clear: got halted=%b err=%b wc=%0d expected 0 0 0", m_halted, s_err, s_wc);
        else passed++;
        @(posedge clk); #1 rst_n = 1;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_odd_length();
        test_halt();
        test_overflow();
        test_gaps();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
